// File: rtl/uart_echo_fifo.sv
// UART loopback: RX decoder -> echo FIFO -> flow-controlled TX, with a hex display of recent bytes.
// Optional build macro UART_ECHO_UPCASE_EN uppercases 'a'-'z' on their way into the echo FIFO.
module uart_echo_fifo #(
    parameter int CLKS_PER_BIT    = 217,
    parameter int FIFO_DEPTH      = 16,
    parameter int NUM_BYTES_SHOWN = 1,
    parameter bit SEG_ACTIVE_LOW  = 1'b1
) (
    input  logic                              i_Clk,
    input  logic                              i_Rst,
    input  logic                              i_UART_RX,
    input  logic                              i_TX_Hold,
    output logic                              o_UART_TX,
    output logic [14*NUM_BYTES_SHOWN-1:0]     o_Segments,
    output logic [$clog2(FIFO_DEPTH):0]       o_Fifo_Count,
    output logic                              o_Overflow,
    output logic                              o_Frame_Err
);

    localparam int CW     = $clog2(CLKS_PER_BIT);
    localparam int AW     = $clog2(FIFO_DEPTH);
    localparam int NDIG   = 2 * NUM_BYTES_SHOWN;
    localparam int DISP_W = 8 * NUM_BYTES_SHOWN;
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'((CLKS_PER_BIT - 1) / 2 - 1);
    localparam logic [AW:0]   FULL      = (AW + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} uart_state_e;

    function automatic logic [6:0] hex_seg(input logic [3:0] n);
        logic [6:0] g;
        case (n)
            4'h0: g = 7'h3F;  4'h1: g = 7'h06;  4'h2: g = 7'h5B;  4'h3: g = 7'h4F;
            4'h4: g = 7'h66;  4'h5: g = 7'h6D;  4'h6: g = 7'h7D;  4'h7: g = 7'h07;
            4'h8: g = 7'h7F;  4'h9: g = 7'h6F;  4'hA: g = 7'h77;  4'hB: g = 7'h7C;
            4'hC: g = 7'h39;  4'hD: g = 7'h5E;  4'hE: g = 7'h79;  default: g = 7'h71;
        endcase
        return SEG_ACTIVE_LOW ? ~g : g;
    endfunction

    function automatic logic [7:0] echo_byte(input logic [7:0] b);
`ifdef UART_ECHO_UPCASE_EN
        return (b >= 8'h61 && b <= 8'h7A) ? b - 8'h20 : b;
`else
        return b;
`endif
    endfunction

    logic rx_meta_q, rx_sync_q;

    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            rx_meta_q <= 1'b1;
            rx_sync_q <= 1'b1;
        end else begin
            rx_meta_q <= i_UART_RX;
            rx_sync_q <= rx_meta_q;
        end
    end

    uart_state_e   rx_state_q;
    logic [CW-1:0] rx_cnt_q;
    logic [2:0]    rx_bit_q;
    logic [7:0]    rx_shift_q;
    logic          rx_strobe_q, rx_bad_q;

    // START resamples near mid-bit; every later sample lands CLKS_PER_BIT after the previous one
    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            rx_state_q  <= S_IDLE;
            rx_cnt_q    <= '0;
            rx_bit_q    <= '0;
            rx_shift_q  <= '0;
            rx_strobe_q <= 1'b0;
            rx_bad_q    <= 1'b0;
        end else begin
            rx_strobe_q <= 1'b0;
            rx_bad_q    <= 1'b0;
            case (rx_state_q)
                S_IDLE: begin
                    rx_cnt_q <= '0;
                    rx_bit_q <= '0;
                    if (!rx_sync_q) rx_state_q <= S_START;
                end
                S_START: begin
                    if (rx_cnt_q == HALF_LAST) begin
                        rx_cnt_q   <= '0;
                        rx_state_q <= rx_sync_q ? S_IDLE : S_DATA;
                    end else begin
                        rx_cnt_q <= rx_cnt_q + CW'(1);
                    end
                end
                S_DATA: begin
                    if (rx_cnt_q == BIT_LAST) begin
                        rx_cnt_q   <= '0;
                        rx_shift_q <= {rx_sync_q, rx_shift_q[7:1]};
                        rx_bit_q   <= rx_bit_q + 3'd1;
                        if (rx_bit_q == 3'd7) rx_state_q <= S_STOP;
                    end else begin
                        rx_cnt_q <= rx_cnt_q + CW'(1);
                    end
                end
                S_STOP: begin
                    if (rx_cnt_q == BIT_LAST) begin
                        rx_cnt_q    <= '0;
                        rx_strobe_q <= rx_sync_q;
                        rx_bad_q    <= ~rx_sync_q;
                        rx_state_q  <= S_IDLE;
                    end else begin
                        rx_cnt_q <= rx_cnt_q + CW'(1);
                    end
                end
                default: rx_state_q <= S_IDLE;
            endcase
        end
    end

    uart_state_e   tx_state_q;
    logic [CW-1:0] tx_cnt_q;
    logic [2:0]    tx_bit_q;
    logic [7:0]    tx_shift_q;
    logic          tx_line_q;
    logic          tx_pop;

    logic [7:0]  mem_q [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          ovf_q, ovf_d, ferr_q, ferr_d;
    logic          push;
    logic [DISP_W-1:0] disp_q, disp_d;
    logic [7*NDIG-1:0] seg_q, seg_d;

    // Fullness is judged on the pre-pop count, so a pop in the same cycle does not rescue the byte
    always_comb begin
        push     = rx_strobe_q && (count_q != FULL);
        tx_pop   = ((tx_state_q == S_IDLE) || (tx_state_q == S_STOP && tx_cnt_q == BIT_LAST))
                   && (count_q != '0) && !i_TX_Hold;
        wr_ptr_d = push   ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = tx_pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
        count_d  = count_q;
        if (push && !tx_pop)      count_d = count_q + (AW + 1)'(1);
        else if (!push && tx_pop) count_d = count_q - (AW + 1)'(1);
        ovf_d    = ovf_q | (rx_strobe_q && count_q == FULL);
        ferr_d   = ferr_q | rx_bad_q;
        disp_d   = rx_strobe_q ? ((disp_q << 8) | DISP_W'(rx_shift_q)) : disp_q;
        seg_d    = '0;
        for (int k = 0; k < NDIG; k++) seg_d[7*k +: 7] = hex_seg(disp_q[4*k +: 4]);
    end

    always_ff @(posedge i_Clk) begin
        if (push) mem_q[wr_ptr_q] <= echo_byte(rx_shift_q);
    end

    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
            ferr_q   <= 1'b0;
            disp_q   <= '0;
            seg_q    <= {NDIG{hex_seg(4'h0)}};
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
            ferr_q   <= ferr_d;
            disp_q   <= disp_d;
            seg_q    <= seg_d;
        end
    end

    // The line register follows the state by one cycle, keeping every bit exactly CLKS_PER_BIT wide
    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            tx_state_q <= S_IDLE;
            tx_cnt_q   <= '0;
            tx_bit_q   <= '0;
            tx_shift_q <= 8'hFF;
            tx_line_q  <= 1'b1;
        end else begin
            case (tx_state_q)
                S_START: tx_line_q <= 1'b0;
                S_DATA:  tx_line_q <= tx_shift_q[0];
                default: tx_line_q <= 1'b1;
            endcase
            case (tx_state_q)
                S_IDLE: begin
                    tx_cnt_q <= '0;
                    tx_bit_q <= '0;
                    if (tx_pop) begin
                        tx_shift_q <= mem_q[rd_ptr_q];
                        tx_state_q <= S_START;
                    end
                end
                S_START: begin
                    if (tx_cnt_q == BIT_LAST) begin
                        tx_cnt_q   <= '0;
                        tx_state_q <= S_DATA;
                    end else begin
                        tx_cnt_q <= tx_cnt_q + CW'(1);
                    end
                end
                S_DATA: begin
                    if (tx_cnt_q == BIT_LAST) begin
                        tx_cnt_q   <= '0;
                        tx_shift_q <= {1'b1, tx_shift_q[7:1]};
                        tx_bit_q   <= tx_bit_q + 3'd1;
                        if (tx_bit_q == 3'd7) tx_state_q <= S_STOP;
                    end else begin
                        tx_cnt_q <= tx_cnt_q + CW'(1);
                    end
                end
                S_STOP: begin
                    if (tx_cnt_q == BIT_LAST) begin
                        tx_cnt_q <= '0;
                        tx_bit_q <= '0;
                        if (tx_pop) begin
                            tx_shift_q <= mem_q[rd_ptr_q];
                            tx_state_q <= S_START;
                        end else begin
                            tx_state_q <= S_IDLE;
                        end
                    end else begin
                        tx_cnt_q <= tx_cnt_q + CW'(1);
                    end
                end
                default: tx_state_q <= S_IDLE;
            endcase
        end
    end

    assign o_UART_TX    = tx_line_q;
    assign o_Segments   = seg_q;
    assign o_Fifo_Count = count_q;
    assign o_Overflow   = ovf_q;
    assign o_Frame_Err  = ferr_q;

endmodule

// File: tb/tb_uart_echo_fifo.sv
// Directed bench for uart_echo_fifo: serial stimulus on RX, scoreboard monitor decoding TX frames.
`timescale 1ns/1ps
module tb_uart_echo_fifo;

    localparam int C  = 8;
    localparam int D  = 4;
    localparam int NB = 2;

`ifdef UART_ECHO_UPCASE_EN
    localparam logic [7:0] ECHO_61 = 8'h41;
`else
    localparam logic [7:0] ECHO_61 = 8'h61;
`endif

    // Active-low glyphs (G..A)
    localparam logic [6:0] S0 = 7'h40, S5 = 7'h12, SA = 7'h08, S6 = 7'h02;
    localparam logic [6:0] S1 = 7'h79, S7 = 7'h78, SE = 7'h06;

    logic        clk = 1'b0;
    logic        rst, rx, hold;
    logic        tx;
    logic [27:0] seg;
    logic [2:0]  cnt;
    logic        ovf, ferr;

    always #5 clk = ~clk;

    uart_echo_fifo #(
        .CLKS_PER_BIT(C), .FIFO_DEPTH(D), .NUM_BYTES_SHOWN(NB), .SEG_ACTIVE_LOW(1'b1)
    ) dut (
        .i_Clk(clk), .i_Rst(rst), .i_UART_RX(rx), .i_TX_Hold(hold),
        .o_UART_TX(tx), .o_Segments(seg), .o_Fifo_Count(cnt),
        .o_Overflow(ovf), .o_Frame_Err(ferr)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    logic [7:0] exp_q[$];
    bit b2b_chk    = 1'b0;
    bit prev_valid = 1'b0;
    int prev_start = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic wait_cyc(input int n, inout bit ab);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (rst) ab = 1'b1;
        end
    endtask

    task automatic uart_send(input logic [7:0] b, input bit good_stop);
        @(negedge clk);
        rx = 1'b0;
        repeat (C) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (C) @(negedge clk);
        end
        if (good_stop) begin
            rx = 1'b1;
            repeat (C) @(negedge clk);
        end else begin
            rx = 1'b0;
            repeat (C / 2) @(negedge clk);
            rx = 1'b1;
            repeat (C) @(negedge clk);
        end
    endtask

    // Monitor: decode every TX frame mid-bit and pop the scoreboard
    initial begin : monitor
        logic       prev;
        logic [7:0] data;
        bit         ab;
        int         start_cyc;
        prev = 1'b1;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev = 1'b1;
            end else if (prev && !tx) begin
                start_cyc = cyc;
                ab = 1'b0;
                data = '0;
                wait_cyc(C / 2, ab);
                if (!ab) chk("start_bit", 32'(tx), 0);
                for (int i = 0; i < 8; i++) begin
                    if (!ab) wait_cyc(C, ab);
                    if (!ab) data[i] = tx;
                end
                if (!ab) wait_cyc(C, ab);
                if (!ab) begin
                    chk("stop_bit", 32'(tx), 1);
                    if (exp_q.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL unexpected_echo: got %0h want none", data);
                    end else begin
                        chk("echo_byte", 32'(data), 32'(exp_q.pop_front()));
                    end
                    if (b2b_chk) begin
                        if (prev_valid) chk("b2b_gap", start_cyc - prev_start, 10 * C);
                        prev_start = start_cyc;
                        prev_valid = 1'b1;
                    end
                end
                prev = 1'b1;
            end else begin
                prev = tx;
            end
        end
    end

    initial begin : stim
        int lows;
        rst = 1'b0; rx = 1'b1; hold = 1'b0;
        #2 rst = 1'b1;
        #20;
        chk("rst_tx", 32'(tx), 1);
        chk("rst_count", 32'(cnt), 0);
        chk("rst_ovf", 32'(ovf), 0);
        chk("rst_ferr", 32'(ferr), 0);
        chk("rst_seg", 32'(seg), 32'({S0, S0, S0, S0}));
        @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);

        exp_q.push_back(8'h5A);
        uart_send(8'h5A, 1'b1);
        repeat (100) @(negedge clk);
        chk("5a_count", 32'(cnt), 0);
        chk("5a_seg", 32'(seg), 32'({S0, S0, S5, SA}));

        hold = 1'b1;
        for (int b = 1; b <= 6; b++) begin
            if (b <= D) exp_q.push_back(8'(b));
            uart_send(8'(b), 1'b1);
        end
        repeat (20) @(negedge clk);
        chk("ovf_count", 32'(cnt), 4);
        chk("ovf_flag", 32'(ovf), 1);
        chk("ovf_seg", 32'(seg), 32'({S0, S5, S0, S6}));
        prev_valid = 1'b0;
        b2b_chk    = 1'b1;
        hold       = 1'b0;
        repeat (4 * 10 * C + 40) @(negedge clk);
        b2b_chk = 1'b0;
        chk("drain_count", 32'(cnt), 0);
        chk("drain_left", exp_q.size(), 0);

        uart_send(8'h33, 1'b0);
        repeat (100) @(negedge clk);
        chk("ferr_flag", 32'(ferr), 1);
        chk("ferr_count", 32'(cnt), 0);
        chk("ferr_seg", 32'(seg), 32'({S0, S5, S0, S6}));

        exp_q.push_back(8'h00);
        uart_send(8'h00, 1'b1);
        repeat (30) @(negedge clk);
        chk("pre_rst_tx", 32'(tx), 0);
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_tx", 32'(tx), 1);
        chk("mid_rst_count", 32'(cnt), 0);
        chk("mid_rst_ovf", 32'(ovf), 0);
        chk("mid_rst_ferr", 32'(ferr), 0);
        chk("mid_rst_seg", 32'(seg), 32'({S0, S0, S0, S0}));
        exp_q.delete();
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);

        exp_q.push_back(8'h7E);
        uart_send(8'h7E, 1'b1);
        repeat (100) @(negedge clk);
        chk("post_rst_count", 32'(cnt), 0);
        chk("post_rst_seg", 32'(seg), 32'({S0, S0, S7, SE}));

        @(negedge clk);
        rx = 1'b0;
        repeat (2) @(negedge clk);
        rx = 1'b1;
        lows = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (!tx) lows++;
        end
        chk("glitch_tx_low", lows, 0);
        chk("glitch_ferr", 32'(ferr), 0);
        chk("glitch_ovf", 32'(ovf), 0);
        chk("glitch_count", 32'(cnt), 0);
        chk("glitch_seg", 32'(seg), 32'({S0, S0, S7, SE}));

        exp_q.push_back(ECHO_61);
        uart_send(8'h61, 1'b1);
        repeat (100) @(negedge clk);
        chk("61_seg", 32'(seg), 32'({S7, SE, S6, S1}));
        chk("61_count", 32'(cnt), 0);
        chk("final_left", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
